// File: rtl/rob_buffer.sv
// rob_buffer: in-order reorder buffer; allocates at tail, records writebacks, retires at head.
// Latency: writeback visible at commit after one edge; alloc_ready/alloc_idx/commit_* are combinational.
// Backpressure: alloc_ready low while full; head holds while commit_ready low. Option: ROB_OPERAND_READ_EN.
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif

module rob_buffer #(
  parameter int ROB_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_en,
  input  logic                      alloc_reg_write_en,
  input  logic [`REG_ADDR_BUS]      alloc_reg_write_addr,
  input  logic [`ADDR_BUS]          alloc_pc,
  input  logic [`EXC_TYPE_BUS]      alloc_exception_type,
  input  logic                      alloc_is_delayslot,
  output logic                      alloc_ready,
  output logic [ROB_ADDR_WIDTH-1:0] alloc_idx,
  input  logic                      wb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] wb_idx,
  input  logic [`DATA_BUS]          wb_data,
  input  logic [`EXC_TYPE_BUS]      wb_exception_type,
`ifdef ROB_OPERAND_READ_EN
  input  logic [ROB_ADDR_WIDTH-1:0] rd_idx_1,
  input  logic [ROB_ADDR_WIDTH-1:0] rd_idx_2,
  output logic                      rd_done_1,
  output logic                      rd_done_2,
  output logic [`DATA_BUS]          rd_data_1,
  output logic [`DATA_BUS]          rd_data_2,
`endif
  input  logic                      commit_ready,
  output logic                      commit_valid,
  output logic [ROB_ADDR_WIDTH-1:0] commit_idx,
  output logic                      commit_reg_write_en,
  output logic [`REG_ADDR_BUS]      commit_reg_write_addr,
  output logic [`DATA_BUS]          commit_data,
  output logic [`ADDR_BUS]          commit_pc,
  output logic [`EXC_TYPE_BUS]      commit_exception_type,
  output logic                      commit_is_delayslot
);

  localparam int DEPTH = 2 ** ROB_ADDR_WIDTH;
  localparam logic [ROB_ADDR_WIDTH:0] PTR_ONE = 1;

  typedef struct packed {
    logic                 reg_write_en;
    logic [`REG_ADDR_BUS] reg_write_addr;
    logic [`ADDR_BUS]     pc;
    logic [`EXC_TYPE_BUS] exc;
    logic                 is_delayslot;
    logic [`DATA_BUS]     data;
  } entry_t;

  entry_t                    entries [DEPTH];
  logic [DEPTH-1:0]          valid;
  logic [DEPTH-1:0]          done;
  logic [ROB_ADDR_WIDTH:0]   head;
  logic [ROB_ADDR_WIDTH:0]   tail;
  logic [ROB_ADDR_WIDTH-1:0] head_idx;
  logic [ROB_ADDR_WIDTH-1:0] tail_idx;
  logic                      empty;
  logic                      full;
  logic                      alloc_fire;
  logic                      wb_fire;
  logic                      commit_fire;
  entry_t                    head_ent;

  assign head_idx    = head[ROB_ADDR_WIDTH-1:0];
  assign tail_idx    = tail[ROB_ADDR_WIDTH-1:0];
  assign empty       = (head == tail);
  // Wrap bits differ with equal index bits: tail has lapped head exactly once.
  assign full        = (head_idx == tail_idx) && (head[ROB_ADDR_WIDTH] != tail[ROB_ADDR_WIDTH]);
  assign alloc_ready = !full;
  assign alloc_idx   = tail_idx;
  assign alloc_fire  = alloc_en && !full;
  assign wb_fire     = wb_en && valid[wb_idx];
  assign commit_valid = !empty && done[head_idx];
  assign commit_fire  = commit_valid && commit_ready;

  assign head_ent              = entries[head_idx];
  assign commit_idx            = head_idx;
  assign commit_reg_write_en   = head_ent.reg_write_en;
  assign commit_reg_write_addr = head_ent.reg_write_addr;
  assign commit_data           = head_ent.data;
  assign commit_pc             = head_ent.pc;
  assign commit_exception_type = head_ent.exc;
  assign commit_is_delayslot   = head_ent.is_delayslot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (wb_fire) begin
        entries[wb_idx].data <= wb_data;
        entries[wb_idx].exc  <= entries[wb_idx].exc | wb_exception_type;
        done[wb_idx]         <= 1'b1;
      end
      // Placed after writeback so a redundant wb to the retiring head cannot resurrect it.
      if (commit_fire) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
        head            <= head + PTR_ONE;
      end
      if (alloc_fire) begin
        entries[tail_idx] <= '{reg_write_en:   alloc_reg_write_en,
                               reg_write_addr: alloc_reg_write_addr,
                               pc:             alloc_pc,
                               exc:            alloc_exception_type,
                               is_delayslot:   alloc_is_delayslot,
                               data:           '0};
        valid[tail_idx]   <= 1'b1;
        done[tail_idx]    <= (alloc_exception_type != '0);
        tail              <= tail + PTR_ONE;
      end
    end
  end

`ifdef ROB_OPERAND_READ_EN
  // Same-cycle writeback to the referenced entry is forwarded ahead of the stored value.
  always_comb begin
    rd_done_1 = 1'b0;
    rd_data_1 = '0;
    rd_done_2 = 1'b0;
    rd_data_2 = '0;
    if (valid[rd_idx_1]) begin
      if (wb_en && (wb_idx == rd_idx_1)) begin
        rd_done_1 = 1'b1;
        rd_data_1 = wb_data;
      end else begin
        rd_done_1 = done[rd_idx_1];
        rd_data_1 = entries[rd_idx_1].data;
      end
    end
    if (valid[rd_idx_2]) begin
      if (wb_en && (wb_idx == rd_idx_2)) begin
        rd_done_2 = 1'b1;
        rd_data_2 = wb_data;
      end else begin
        rd_done_2 = done[rd_idx_2];
        rd_data_2 = entries[rd_idx_2].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_buffer.sv
// Testbench for rob_buffer: directed scenarios plus randomized traffic against a queue-based model.
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif

module tb_rob_buffer;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 alloc_en = 1'b0;
  logic                 alloc_reg_write_en = 1'b0;
  logic [`REG_ADDR_BUS] alloc_reg_write_addr = '0;
  logic [`ADDR_BUS]     alloc_pc = '0;
  logic [`EXC_TYPE_BUS] alloc_exception_type = '0;
  logic                 alloc_is_delayslot = 1'b0;
  logic                 alloc_ready;
  logic [3:0]           alloc_idx;
  logic                 wb_en = 1'b0;
  logic [3:0]           wb_idx = '0;
  logic [`DATA_BUS]     wb_data = '0;
  logic [`EXC_TYPE_BUS] wb_exception_type = '0;
  logic                 commit_ready = 1'b0;
  logic                 commit_valid;
  logic [3:0]           commit_idx;
  logic                 commit_reg_write_en;
  logic [`REG_ADDR_BUS] commit_reg_write_addr;
  logic [`DATA_BUS]     commit_data;
  logic [`ADDR_BUS]     commit_pc;
  logic [`EXC_TYPE_BUS] commit_exception_type;
  logic                 commit_is_delayslot;
`ifdef ROB_OPERAND_READ_EN
  logic [3:0]           rd_idx_1 = '0;
  logic [3:0]           rd_idx_2 = '0;
  logic                 rd_done_1;
  logic                 rd_done_2;
  logic [`DATA_BUS]     rd_data_1;
  logic [`DATA_BUS]     rd_data_2;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: program-order queue of live indices plus per-slot fields.
  int                   q[$];
  int                   m_tail;
  bit                   m_valid [16];
  bit                   m_done  [16];
  logic [`DATA_BUS]     m_data  [16];
  logic [`ADDR_BUS]     m_pc    [16];
  logic [`EXC_TYPE_BUS] m_exc   [16];
  logic                 m_we    [16];
  logic [`REG_ADDR_BUS] m_addr  [16];
  logic                 m_ds    [16];

  rob_buffer #(.ROB_ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_en(alloc_en), .alloc_reg_write_en(alloc_reg_write_en),
    .alloc_reg_write_addr(alloc_reg_write_addr), .alloc_pc(alloc_pc),
    .alloc_exception_type(alloc_exception_type), .alloc_is_delayslot(alloc_is_delayslot),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .wb_exception_type(wb_exception_type),
`ifdef ROB_OPERAND_READ_EN
    .rd_idx_1(rd_idx_1), .rd_idx_2(rd_idx_2), .rd_done_1(rd_done_1), .rd_done_2(rd_done_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
`endif
    .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_idx(commit_idx),
    .commit_reg_write_en(commit_reg_write_en), .commit_reg_write_addr(commit_reg_write_addr),
    .commit_data(commit_data), .commit_pc(commit_pc),
    .commit_exception_type(commit_exception_type), .commit_is_delayslot(commit_is_delayslot)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_data[i] = '0; m_pc[i] = '0;
      m_exc[i] = '0; m_we[i] = 1'b0; m_addr[i] = '0; m_ds[i] = 1'b0;
    end
  endtask

  // Applies the current inputs to the model as the coming clock edge would.
  task automatic model_edge();
    int  n;
    bit  cv;
    n  = q.size();
    cv = (n > 0) && m_done[q[0]];
    if (flush) begin
      q.delete();
      m_tail = 0;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_done[i] = 0; end
    end else begin
      if (wb_en && m_valid[wb_idx]) begin
        m_data[wb_idx] = wb_data;
        m_exc[wb_idx]  = m_exc[wb_idx] | wb_exception_type;
        m_done[wb_idx] = 1;
      end
      if (cv && commit_ready) begin
        m_valid[q[0]] = 0;
        m_done[q[0]]  = 0;
        void'(q.pop_front());
      end
      if (alloc_en && n < 16) begin
        m_valid[m_tail] = 1;
        m_done[m_tail]  = (alloc_exception_type != '0);
        m_data[m_tail]  = '0;
        m_pc[m_tail]    = alloc_pc;
        m_exc[m_tail]   = alloc_exception_type;
        m_we[m_tail]    = alloc_reg_write_en;
        m_addr[m_tail]  = alloc_reg_write_addr;
        m_ds[m_tail]    = alloc_is_delayslot;
        q.push_back(m_tail);
        m_tail = (m_tail + 1) % 16;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_en = 0; wb_en = 0; commit_ready = 0;
    alloc_exception_type = '0; wb_exception_type = '0;
  endtask

  task automatic alloc_one(input logic [`ADDR_BUS] pc, input logic [`EXC_TYPE_BUS] exc);
    alloc_en = 1; alloc_pc = pc; alloc_exception_type = exc;
    alloc_reg_write_en = 1; alloc_reg_write_addr = pc[6:2]; alloc_is_delayslot = pc[2];
    tick();
    alloc_en = 0; alloc_exception_type = '0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
    tests++; if (alloc_idx !== 4'd0) begin fails++; $display("FAIL reset_alloc_idx got=%0d exp=0", alloc_idx); end
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL reset_commit_valid got=%0b exp=0", commit_valid); end
    tests++; if (commit_data !== '0) begin fails++; $display("FAIL reset_commit_data got=%0h exp=0", commit_data); end
    rst = 0;
    #1;
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (alloc_idx !== 4'(i)) begin fails++; $display("FAIL order_alloc_idx got=%0d exp=%0d", alloc_idx, i); end
      alloc_one(32'h100 + 32'(4 * i), '0);
    end
    wb_en = 1; wb_idx = 4'd1; wb_data = 32'h22; tick();
    wb_en = 0; #1;
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL order_head_not_done got=%0b exp=0", commit_valid); end
    wb_en = 1; wb_idx = 4'd0; wb_data = 32'h11; tick();
    wb_en = 0; #1;
    tests++; if (commit_valid !== 1'b1 || commit_idx !== 4'd0 || commit_data !== 32'h11 || commit_pc !== 32'h100)
      begin fails++; $display("FAIL order_first v=%0b idx=%0d data=%0h pc=%0h exp=1/0/11/100", commit_valid, commit_idx, commit_data, commit_pc); end
    commit_ready = 1; tick(); #1;
    tests++; if (commit_valid !== 1'b1 || commit_idx !== 4'd1 || commit_data !== 32'h22 || commit_pc !== 32'h104)
      begin fails++; $display("FAIL order_second v=%0b idx=%0d data=%0h pc=%0h exp=1/1/22/104", commit_valid, commit_idx, commit_data, commit_pc); end
    tick(); #1;
    tests++; if (commit_valid !== 1'b0 || commit_idx !== 4'd2) begin fails++; $display("FAIL order_idx2_pending v=%0b idx=%0d exp=0/2", commit_valid, commit_idx); end
    wb_en = 1; wb_idx = 4'd2; wb_data = 32'h33; tick();
    wb_en = 0; tick();
    idle_inputs();
  endtask

  task automatic test_full();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 16; i++) alloc_one(32'h200 + 32'(4 * i), '0);
    alloc_en = 1; alloc_pc = 32'hDEAD; #1;
    tests++; if (alloc_ready !== 1'b0 || alloc_idx !== 4'd0) begin fails++; $display("FAIL full_ready rdy=%0b idx=%0d exp=0/0", alloc_ready, alloc_idx); end
    tick(); alloc_en = 0;
    wb_en = 1; wb_idx = 4'd0; wb_data = 32'h55; tick(); wb_en = 0;
    commit_ready = 1; alloc_en = 1; alloc_pc = 32'h300; #1;
    tests++; if (commit_valid !== 1'b1 || alloc_ready !== 1'b0) begin fails++; $display("FAIL full_no_reuse v=%0b rdy=%0b exp=1/0", commit_valid, alloc_ready); end
    tick(); alloc_en = 0; commit_ready = 0; #1;
    tests++; if (alloc_ready !== 1'b1 || alloc_idx !== 4'd0 || commit_idx !== 4'd1 || commit_valid !== 1'b0)
      begin fails++; $display("FAIL full_one_free rdy=%0b idx=%0d head=%0d v=%0b exp=1/0/1/0", alloc_ready, alloc_idx, commit_idx, commit_valid); end
    alloc_one(32'h400, '0); #1;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_again got=%0b exp=0", alloc_ready); end
    flush = 1; tick(); idle_inputs();
  endtask

  task automatic test_exception();
    alloc_one(32'h500, 5'h4); #1;
    tests++; if (commit_valid !== 1'b1 || commit_exception_type !== 5'h4 || commit_pc !== 32'h500)
      begin fails++; $display("FAIL exc_commit v=%0b exc=%0h pc=%0h exp=1/4/500", commit_valid, commit_exception_type, commit_pc); end
    commit_ready = 1; tick(); idle_inputs();
  endtask

  task automatic test_flush();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 5; i++) alloc_one(32'h600 + 32'(4 * i), '0);
    flush = 1; alloc_en = 1; alloc_pc = 32'h700; wb_en = 1; wb_idx = 4'd0; wb_data = 32'h77; commit_ready = 1;
    tick(); idle_inputs(); #1;
    tests++; if (commit_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0)
      begin fails++; $display("FAIL flush_empty v=%0b rdy=%0b idx=%0d exp=0/1/0", commit_valid, alloc_ready, alloc_idx); end
    alloc_one(32'h800, '0); #1;
    tests++; if (commit_valid !== 1'b0 || alloc_idx !== 4'd1 || commit_pc !== 32'h800)
      begin fails++; $display("FAIL flush_no_residue v=%0b idx=%0d pc=%0h exp=0/1/800", commit_valid, alloc_idx, commit_pc); end
  endtask

  task automatic test_async_reset();
    alloc_one(32'h900, 5'h2);
    alloc_one(32'h904, '0);
    #2 rst = 1;
    #1;
    tests++; if (alloc_idx !== 4'd0 || commit_valid !== 1'b0 || alloc_ready !== 1'b1 || commit_pc !== '0)
      begin fails++; $display("FAIL async_reset idx=%0d v=%0b rdy=%0b pc=%0h exp=0/0/1/0", alloc_idx, commit_valid, alloc_ready, commit_pc); end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

`ifdef ROB_OPERAND_READ_EN
  task automatic test_operand();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 4; i++) alloc_one(32'hA00 + 32'(4 * i), '0);
    wb_en = 1; wb_idx = 4'd3; wb_data = 32'hABCD; rd_idx_1 = 4'd3; rd_idx_2 = 4'd5; #1;
    tests++; if (rd_done_1 !== 1'b1 || rd_data_1 !== 32'hABCD) begin fails++; $display("FAIL rd_bypass done=%0b data=%0h exp=1/abcd", rd_done_1, rd_data_1); end
    tests++; if (rd_done_2 !== 1'b0 || rd_data_2 !== '0) begin fails++; $display("FAIL rd_invalid done=%0b data=%0h exp=0/0", rd_done_2, rd_data_2); end
    tick(); wb_en = 0; #1;
    tests++; if (rd_done_1 !== 1'b1 || rd_data_1 !== 32'hABCD) begin fails++; $display("FAIL rd_stored done=%0b data=%0h exp=1/abcd", rd_done_1, rd_data_1); end
    flush = 1; tick(); idle_inputs();
  endtask
`endif

  task automatic test_random();
    bit                 e_cv;
    int                 h;
    logic               e_done;
    logic [`DATA_BUS]   e_data;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush = ($urandom_range(0, 99) < 2);
      alloc_en = ($urandom_range(0, 99) < 60);
      alloc_pc = $urandom; alloc_reg_write_en = 1'($urandom); alloc_reg_write_addr = 5'($urandom);
      alloc_is_delayslot = 1'($urandom);
      alloc_exception_type = ($urandom_range(0, 99) < 8) ? 5'($urandom_range(1, 31)) : 5'd0;
      wb_en = ($urandom_range(0, 99) < 50);
      wb_idx = (q.size() > 0 && $urandom_range(0, 3) != 0) ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'($urandom);
      wb_data = $urandom;
      wb_exception_type = ($urandom_range(0, 99) < 5) ? 5'($urandom) : 5'd0;
      commit_ready = ($urandom_range(0, 99) < 70);
`ifdef ROB_OPERAND_READ_EN
      rd_idx_1 = ($urandom_range(0, 1) != 0) ? wb_idx : 4'($urandom);
      rd_idx_2 = 4'($urandom);
`endif
      #1;
      e_cv = (q.size() > 0) && m_done[q[0]];
      tests++; if (alloc_ready !== (q.size() < 16)) begin fails++; $display("FAIL rnd_alloc_ready cyc=%0d got=%0b exp=%0b", cyc, alloc_ready, q.size() < 16); end
      tests++; if (alloc_idx !== 4'(m_tail)) begin fails++; $display("FAIL rnd_alloc_idx cyc=%0d got=%0d exp=%0d", cyc, alloc_idx, m_tail); end
      tests++; if (commit_valid !== e_cv) begin fails++; $display("FAIL rnd_commit_valid cyc=%0d got=%0b exp=%0b", cyc, commit_valid, e_cv); end
      if (e_cv) begin
        h = q[0];
        tests++;
        if (commit_idx !== 4'(h) || commit_data !== m_data[h] || commit_pc !== m_pc[h] || commit_exception_type !== m_exc[h] ||
            commit_reg_write_en !== m_we[h] || commit_reg_write_addr !== m_addr[h] || commit_is_delayslot !== m_ds[h]) begin
          fails++;
          $display("FAIL rnd_commit_fields cyc=%0d idx=%0d/%0d data=%0h/%0h pc=%0h/%0h exc=%0h/%0h we=%0b/%0b addr=%0d/%0d ds=%0b/%0b",
                   cyc, commit_idx, h, commit_data, m_data[h], commit_pc, m_pc[h], commit_exception_type, m_exc[h],
                   commit_reg_write_en, m_we[h], commit_reg_write_addr, m_addr[h], commit_is_delayslot, m_ds[h]);
        end
      end
`ifdef ROB_OPERAND_READ_EN
      e_done = m_valid[rd_idx_1] && (m_done[rd_idx_1] || (wb_en && wb_idx == rd_idx_1));
      e_data = !m_valid[rd_idx_1] ? '0 : (wb_en && wb_idx == rd_idx_1) ? wb_data : m_data[rd_idx_1];
      tests++; if (rd_done_1 !== e_done || rd_data_1 !== e_data) begin fails++; $display("FAIL rnd_rd1 cyc=%0d done=%0b/%0b data=%0h/%0h", cyc, rd_done_1, e_done, rd_data_1, e_data); end
      e_done = m_valid[rd_idx_2] && (m_done[rd_idx_2] || (wb_en && wb_idx == rd_idx_2));
      e_data = !m_valid[rd_idx_2] ? '0 : (wb_en && wb_idx == rd_idx_2) ? wb_data : m_data[rd_idx_2];
      tests++; if (rd_done_2 !== e_done || rd_data_2 !== e_data) begin fails++; $display("FAIL rnd_rd2 cyc=%0d done=%0b/%0b data=%0h/%0h", cyc, rd_done_2, e_done, rd_data_2, e_data); end
`else
      e_done = 1'b0;
      e_data = '0;
`endif
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_exception();
    test_flush();
    test_async_reset();
`ifdef ROB_OPERAND_READ_EN
    test_operand();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
